// File: rtl/regfile_writeback_if.sv
// Result-source bundle for the register-file writer: the single-cycle ALU
// result and the long-latency unit's valid/ready handshake.
interface regfile_writeback_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lng_valid;
   logic [4:0]  lng_rd;
   logic [31:0] lng_data;
   logic        lng_ready;

   // Execution units drive results and observe lng_ready.
   modport master (
      output alu_valid, alu_rd, alu_data,
      output lng_valid, lng_rd, lng_data,
      input  lng_ready
   );

   // The writer consumes results and backpressures the long unit.
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lng_valid, lng_rd, lng_data,
      output lng_ready
   );
endinterface

// File: rtl/regfile_writeback.sv
// Writer side of the 32x32 register file. ALU results always own the single
// write port; long-latency results wait in a small in-order queue and drain
// on cycles where the ALU has nothing to retire. Also provides read bypass
// from the registered write port and pending-write flags for the hazard unit.
module regfile_writeback #(
   parameter int DEPTH = 4,   // queue entries, power of two, >= 2
   parameter int AW    = 2    // log2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_writeback_if.slave   res,
   output logic                 RegWr,
   output logic [4:0]           RW,
   output logic [31:0]          BusW,
   input  logic [4:0]           RA,
   input  logic [4:0]           RB,
   input  logic [31:0]          BusA_rf,
   input  logic [31:0]          BusB_rf,
   output logic [31:0]          BusA,
   output logic [31:0]          BusB,
   output logic                 pend_a,
   output logic                 pend_b
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   // Queue storage: rd/data are plain storage, live marks an entry that is
   // both occupied and still allowed to write (cleared on pop and on kill).
   logic [4:0]       rd_mem_q   [DEPTH];
   logic [31:0]      data_mem_q [DEPTH];
   logic [DEPTH-1:0] live_q, live_d;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;

   // Registered write port.
   logic             regwr_q, regwr_d;
   logic [4:0]       rw_q,    rw_d;
   logic [31:0]      busw_q,  busw_d;

   logic             alu_wr;     // ALU owns the port and writes a real register
   logic             push;       // accepted long result that must be queued
   logic             push_live;  // queued entry survives a same-cycle ALU kill
   logic             pop;        // head leaves the queue this cycle

   // No pop-through: a full queue refuses even when the head drains this cycle.
   assign res.lng_ready = rst_n && (count_q != FULL);

   assign alu_wr    = res.alu_valid && (res.alu_rd != 5'd0);
   assign push      = res.lng_valid && res.lng_ready && (res.lng_rd != 5'd0);
   assign push_live = !(alu_wr && (res.lng_rd == res.alu_rd));
   // Any valid ALU slot, even to r0, blocks the drain for that cycle.
   assign pop       = !res.alu_valid && (count_q != '0);

   // Queue next state: kill matching entries, retire head, append new entry.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
      live_d   = live_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      // The ALU result is younger than anything queued, so older writes to
      // the same register must never reach the file.
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_wr && (rd_mem_q[i] == res.alu_rd)) begin
            live_d[i] = 1'b0;
         end
      end

      if (pop) begin
         live_d[rd_ptr_q] = 1'b0;
         rd_ptr_d         = rd_ptr_q + 1'b1;
      end

      // Pop and push never target the same slot: a pop needs count > 0 and a
      // push needs count < DEPTH, so the pointers differ whenever both fire.
      if (push) begin
         live_d[wr_ptr_q] = push_live;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Write-port selection: ALU first, then queue head, otherwise idle.
   always_comb begin
      regwr_d = 1'b0;
      rw_d    = rw_q;
      busw_d  = busw_q;
      if (res.alu_valid) begin
         if (alu_wr) begin
            regwr_d = 1'b1;
            rw_d    = res.alu_rd;
            busw_d  = res.alu_data;
         end
      end else if (pop) begin
         // A killed head still takes its slot but leaves RegWr low.
         regwr_d = live_q[rd_ptr_q];
         rw_d    = rd_mem_q[rd_ptr_q];
         busw_d  = data_mem_q[rd_ptr_q];
      end
   end

   // Control and write-port registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         live_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         regwr_q  <= 1'b0;
         rw_q     <= 5'd0;
         busw_q   <= 32'd0;
      end else begin
         live_q   <= live_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         regwr_q  <= regwr_d;
         rw_q     <= rw_d;
         busw_q   <= busw_d;
      end
   end

   // Queue payload storage, written on push only.
   always_ff @(posedge clk) begin
      // NOTE: payload storage is not reset; the reset-cleared live bits already mark every slot empty.
      if (push) begin
         rd_mem_q[wr_ptr_q]   <= res.lng_rd;
         data_mem_q[wr_ptr_q] <= res.lng_data;
      end
   end

   assign RegWr = regwr_q;
   assign RW    = rw_q;
   assign BusW  = busw_q;

   // Pending-write flags from live queue entries (pre-edge view).
   always_comb begin
      pend_a = 1'b0;
      pend_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_q[i] && (rd_mem_q[i] == RA)) pend_a = 1'b1;
         if (live_q[i] && (rd_mem_q[i] == RB)) pend_b = 1'b1;
      end
      if (RA == 5'd0) pend_a = 1'b0;
      if (RB == 5'd0) pend_b = 1'b0;
   end

   // Same-cycle bypass of the write currently presented to the file.
   assign BusA = (regwr_q && (rw_q == RA) && (RA != 5'd0)) ? busw_q : BusA_rf;
   assign BusB = (regwr_q && (rw_q == RB) && (RB != 5'd0)) ? busw_q : BusB_rf;

   // Occupancy can never exceed the queue size.
   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= FULL);

   // Live entries must lie inside the occupied region, so never more than count.
   a_live_bound: assert property (@(posedge clk) disable iff (!rst_n)
      $countones(live_q) <= int'(count_q));

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback. Expected register-file writes are
// queued as stimulus is driven and matched against RegWr/RW/BusW by a monitor.
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  RA, RB, RW;
   logic [31:0] BusA_rf, BusB_rf, BusW, BusA, BusB;
   logic        RegWr, pend_a, pend_b;

   regfile_writeback_if bus ();

   regfile_writeback #(.DEPTH(4), .AW(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .res     (bus),
      .RegWr   (RegWr),
      .RW      (RW),
      .BusW    (BusW),
      .RA      (RA),
      .RB      (RB),
      .BusA_rf (BusA_rf),
      .BusB_rf (BusB_rf),
      .BusA    (BusA),
      .BusB    (BusB),
      .pend_a  (pend_a),
      .pend_b  (pend_b)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next active edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = rd;
      bus.alu_data  = data;
      if (rd != 5'd0) sb.push_back('{rd: rd, data: data});
   endtask

   task automatic drive_lng(input logic [4:0] rd, input logic [31:0] data);
      bus.lng_valid = 1'b1;
      bus.lng_rd    = rd;
      bus.lng_data  = data;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
      sb.push_back('{rd: rd, data: data});
   endtask

   task automatic quiet();
      bus.alu_valid = 1'b0;
      bus.lng_valid = 1'b0;
   endtask

   // Every write to the file must be the oldest outstanding expected write.
   always @(negedge clk) begin
      if (RegWr === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write", {27'd0, RW}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_rd", {27'd0, RW}, {27'd0, e.rd});
            check("wr_data", BusW, e.data);
         end
      end
   end

   initial begin
      int  idx;
      logic acc;

      rst_n   = 1'b0;
      RA      = 5'd0;
      RB      = 5'd0;
      BusA_rf = 32'd0;
      BusB_rf = 32'd0;
      bus.alu_rd   = 5'd0;
      bus.alu_data = 32'd0;
      bus.lng_rd   = 5'd0;
      bus.lng_data = 32'd0;
      quiet();

      // Reset then idle.
      tick();
      tick();
      rst_n = 1'b1;
      RA = 5'd7;
      RB = 5'd7;
      #1;
      check("rst_regwr", {31'd0, RegWr}, 32'd0);
      check("rst_rw", {27'd0, RW}, 32'd0);
      check("rst_busw", BusW, 32'd0);
      check("rst_ready", {31'd0, bus.lng_ready}, 32'd1);
      check("rst_pend_a", {31'd0, pend_a}, 32'd0);
      check("rst_pend_b", {31'd0, pend_b}, 32'd0);

      // ALU only, plus bypass.
      drive_alu(5'd5, 32'hDEAD_BEEF);
      tick();
      quiet();
      RA = 5'd5;
      RB = 5'd4;
      BusA_rf = 32'h1234_5678;
      BusB_rf = 32'h8765_4321;
      #1;
      check("byp_a_hit", BusA, 32'hDEAD_BEEF);
      check("byp_b_miss", BusB, 32'h8765_4321);
      RB = 5'd5;
      #1;
      check("byp_b_hit", BusB, 32'hDEAD_BEEF);
      tick();
      #1;
      check("byp_a_idle", BusA, 32'h1234_5678);

      // Contention and order.
      drive_alu(5'd9, 32'h900);
      drive_lng(5'd7, 32'h11);
      RA = 5'd7;
      RB = 5'd8;
      tick();
      drive_alu(5'd9, 32'h901);
      drive_lng(5'd8, 32'h22);
      #1;
      check("cont_pend_a_q", {31'd0, pend_a}, 32'd1);
      check("cont_pend_b_pre", {31'd0, pend_b}, 32'd0);
      tick();
      bus.lng_valid = 1'b0;
      drive_alu(5'd9, 32'h902);
      expect_wr(5'd7, 32'h11);
      expect_wr(5'd8, 32'h22);
      #1;
      check("cont_pend_b_q", {31'd0, pend_b}, 32'd1);
      tick();
      quiet();
      #1;
      check("cont_pend_a_popcyc", {31'd0, pend_a}, 32'd1);
      tick();
      #1;
      check("cont_pend_a_gone", {31'd0, pend_a}, 32'd0);
      check("cont_r7_out", {27'd0, RW}, 32'd7);
      tick();
      tick();
      check("cont_drained", sb.size(), 32'd0);

      // Full queue with the ALU busy; producer advances only on handshake.
      idx = 0;
      for (int k = 0; k < 8; k++) begin
         if (k < 6) drive_alu(5'd10, 32'(32'hA00 + k));
         else       bus.alu_valid = 1'b0;
         if (k == 6) begin
            for (int j = 0; j < 5; j++) expect_wr(5'(11 + j), 32'(32'hB00 + j));
         end
         if (idx < 5) drive_lng(5'(11 + idx), 32'(32'hB00 + idx));
         else         bus.lng_valid = 1'b0;
         #1;
         check($sformatf("full_ready_%0d", k), {31'd0, bus.lng_ready},
               (k < 4 || k == 7) ? 32'd1 : 32'd0);
         acc = bus.lng_valid && bus.lng_ready;
         tick();
         if (acc) idx++;
      end
      quiet();
      check("full_accepts", idx, 32'd5);
      repeat (6) tick();
      check("full_drained", sb.size(), 32'd0);

      // WAW kill of a queued entry.
      drive_alu(5'd20, 32'h2020);
      drive_lng(5'd3, 32'hAAAA);
      RA = 5'd3;
      tick();
      bus.lng_valid = 1'b0;
      drive_alu(5'd3, 32'hBBBB);
      #1;
      check("waw_pend_before", {31'd0, pend_a}, 32'd1);
      tick();
      quiet();
      #1;
      check("waw_pend_after", {31'd0, pend_a}, 32'd0);
      tick();
      #1;
      check("waw_killed_pop", {31'd0, RegWr}, 32'd0);

      // Same-cycle kill: long result and ALU to the same rd.
      drive_alu(5'd4, 32'h5555);
      drive_lng(5'd4, 32'h4444);
      RA = 5'd4;
      tick();
      quiet();
      #1;
      check("waw_same_pend", {31'd0, pend_a}, 32'd0);
      tick();
      #1;
      check("waw_same_pop", {31'd0, RegWr}, 32'd0);
      tick();

      // Long push to r0: accepted but never written.
      drive_lng(5'd0, 32'hDEAD);
      #1;
      check("r0_ready", {31'd0, bus.lng_ready}, 32'd1);
      tick();
      quiet();
      repeat (3) begin
         tick();
         check("r0_nowrite", {31'd0, RegWr}, 32'd0);
      end

      // ALU slot to r0 consumes the port without popping.
      drive_alu(5'd21, 32'h2121);
      drive_lng(5'd22, 32'h2222);
      RA = 5'd22;
      tick();
      bus.lng_valid = 1'b0;
      drive_alu(5'd0, 32'hFFFF);
      #1;
      check("alu0_pend", {31'd0, pend_a}, 32'd1);
      tick();
      quiet();
      expect_wr(5'd22, 32'h2222);
      #1;
      check("alu0_regwr", {31'd0, RegWr}, 32'd0);
      tick();
      tick();
      check("alu0_drained", sb.size(), 32'd0);

      // Reset with three entries queued.
      for (int k = 0; k < 3; k++) begin
         drive_alu(5'd23, 32'(32'h2300 + k));
         drive_lng(5'(24 + k), 32'(32'h2400 + k));
         tick();
      end
      quiet();
      RA = 5'd24;
      rst_n = 1'b0;
      #1;
      check("rst2_ready_low", {31'd0, bus.lng_ready}, 32'd0);
      check("rst2_pend_pre", {31'd0, pend_a}, 32'd1);
      tick();
      check("rst2_regwr", {31'd0, RegWr}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst2_ready", {31'd0, bus.lng_ready}, 32'd1);
      check("rst2_pend", {31'd0, pend_a}, 32'd0);
      repeat (3) begin
         tick();
         check("rst2_nowrite", {31'd0, RegWr}, 32'd0);
      end

      check("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
